// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the ram1 built-in self-test controller.
package ram_bist_pkg;

    localparam int DEF_ADDR_SIZE = 10;
    localparam int DEF_WORD_SIZE = 8;
    localparam int DEF_MEM_DEPTH = 1024;
    localparam int DEF_SEED      = 3;
    localparam int DEF_ERR_W     = 16;
    localparam int PAT_W         = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_PULSE,
        WR_GAP,
        RD,
        DONE
    } state_e;

    // Wide 2*addr+seed; callers keep only the low WORD_SIZE bits, which is the mod.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] addr,
                                                 input logic [PAT_W-1:0] seed);
        return (addr << 1) + seed;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-back checker: registered mismatch count (saturating) and first failing address.
module ram_bist_cmp #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] exp_i,
    input  logic [WORD_SIZE-1:0] act_i,
    output logic [ERR_W-1:0]     err_count_o,
    output logic [ADDR_SIZE-1:0] first_err_addr_o,
    output logic                 err_zero_d_o
);

    logic [ERR_W-1:0]     err_q, err_d;
    logic [ADDR_SIZE-1:0] ferr_q, ferr_d;
    logic                 miss;

    always_comb begin
        miss   = en_i && (act_i != exp_i);
        err_d  = err_q;
        ferr_d = ferr_q;
        if (clear_i) begin
            err_d  = '0;
            ferr_d = '0;
        end else if (miss) begin
            if (err_q == '0) ferr_d = addr_i;
            if (!(&err_q))   err_d  = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            ferr_q <= '0;
        end else begin
            err_q  <= err_d;
            ferr_q <= ferr_d;
        end
    end

    // Lets the controller register pass on the same edge as the last compare.
    assign err_zero_d_o     = (err_d == '0);
    assign err_count_o      = err_q;
    assign first_err_addr_o = ferr_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// Write-pattern / read-compare BIST sequencer driving the ram1 pins; all outputs registered.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int SEED      = DEF_SEED,
    parameter int ERR_W     = DEF_ERR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_data_in,
    output logic                 ram_wr,
    output logic                 ram_cs,
    input  logic [WORD_SIZE-1:0] ram_data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [ADDR_SIZE-1:0] first_err_addr
);

    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_SIZE-1:0] ram_data_in_q, ram_data_in_d;
    logic                 ram_wr_q, ram_wr_d;
    logic                 ram_cs_q, ram_cs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 start_acc, last, err_zero_d;
    logic [WORD_SIZE-1:0] rd_exp;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_acc = 1'b0;
        last      = (addr_q == LAST);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WR_PULSE;
                    addr_d    = '0;
                    start_acc = 1'b1;
                end
            end
            WR_PULSE: state_d = WR_GAP;
            WR_GAP: begin
                if (last) begin
                    state_d = RD;
                    addr_d  = '0;
                end else begin
                    state_d = WR_PULSE;
                    addr_d  = addr_q + ADDR_SIZE'(1);
                end
            end
            RD: begin
                if (last) state_d = DONE;
                else      addr_d  = addr_q + ADDR_SIZE'(1);
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear in that state's cycle.
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_wr_d      = 1'b0;
        ram_cs_d      = 1'b0;
        case (state_d)
            WR_PULSE: begin
                ram_wr_d      = 1'b1;
                ram_cs_d      = 1'b1;
                ram_addr_d    = addr_d;
                ram_data_in_d = WORD_SIZE'(pattern(PAT_W'(addr_d), PAT_W'(SEED)));
            end
            RD: begin
                ram_cs_d   = 1'b1;
                ram_addr_d = addr_d;
            end
            default: ;
        endcase

        busy_d = (state_d == WR_PULSE) || (state_d == WR_GAP) || (state_d == RD);
        done_d = (state_d == DONE);
        pass_d = pass_q;
        if (start_acc)                  pass_d = 1'b0;
        else if (state_q == RD && last) pass_d = err_zero_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_wr_q      <= 1'b0;
            ram_cs_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_wr_q      <= ram_wr_d;
            ram_cs_q      <= ram_cs_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign rd_exp = WORD_SIZE'(pattern(PAT_W'(addr_q), PAT_W'(SEED)));

    ram_bist_cmp #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE),
        .ERR_W     (ERR_W)
    ) u_cmp (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (start_acc),
        .en_i             (state_q == RD),
        .addr_i           (addr_q),
        .exp_i            (rd_exp),
        .act_i            (ram_data_out),
        .err_count_o      (err_count),
        .first_err_addr_o (first_err_addr),
        .err_zero_d_o     (err_zero_d)
    );

    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_wr      = ram_wr_q;
    assign ram_cs      = ram_cs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench: default-size controller on a faultable ram1 model, plus two small configs.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: defaults, ram model with optional stuck bit
    logic       start_a, ram_wr_a, ram_cs_a, busy_a, done_a, pass_a, we_a;
    logic [9:0] ram_addr_a, ferr_a;
    logic [7:0] ram_din_a, ram_dout_a;
    logic [15:0] err_a;
    // DUT B: ERR_W=4, MEM_DEPTH=32, ram that ignores writes
    logic       start_b, ram_wr_b, ram_cs_b, busy_b, done_b, pass_b;
    logic [9:0] ram_addr_b, ferr_b;
    logic [7:0] ram_din_b, ram_dout_b;
    logic [3:0] err_b;
    // DUT C: MEM_DEPTH=16, SEED=0, healthy ram
    logic       start_c, ram_wr_c, ram_cs_c, busy_c, done_c, pass_c, we_c;
    logic [9:0] ram_addr_c, ferr_c;
    logic [7:0] ram_din_c, ram_dout_c;
    logic [15:0] err_c;

    ram_bist_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .ram_addr(ram_addr_a), .ram_data_in(ram_din_a), .ram_wr(ram_wr_a), .ram_cs(ram_cs_a),
        .ram_data_out(ram_dout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_err_addr(ferr_a)
    );

    ram_bist_ctrl #(.ERR_W(4), .MEM_DEPTH(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .ram_addr(ram_addr_b), .ram_data_in(ram_din_b), .ram_wr(ram_wr_b), .ram_cs(ram_cs_b),
        .ram_data_out(ram_dout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_addr(ferr_b)
    );

    ram_bist_ctrl #(.MEM_DEPTH(16), .SEED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .ram_addr(ram_addr_c), .ram_data_in(ram_din_c), .ram_wr(ram_wr_c), .ram_cs(ram_cs_c),
        .ram_data_out(ram_dout_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_err_addr(ferr_c)
    );

    // ram1 models: write latched when the wr/cs pulse ends, combinational read
    logic [7:0] mem_a   [1024];
    logic [7:0] mem_c   [1024];
    logic [7:0] wr_seen [1024];
    int mode;

    assign we_a = ram_wr_a & ram_cs_a;
    assign we_c = ram_wr_c & ram_cs_c;
    always @(negedge we_a) begin
        mem_a[ram_addr_a]   = ram_din_a;
        wr_seen[ram_addr_a] = ram_din_a;
    end
    always @(negedge we_c) mem_c[ram_addr_c] = ram_din_c;

    assign ram_dout_a = (mode == 1 && ram_addr_a == 10'd5) ? (mem_a[ram_addr_a] & 8'hFE)
                                                           : mem_a[ram_addr_a];
    assign ram_dout_b = 8'h00;
    assign ram_dout_c = mem_c[ram_addr_c];

    int errors = 0;
    int checks = 0;
    int cyc;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int mode;
        int exp_cyc;
        int exp_pass;
        int exp_err;
        int exp_ferr;
    } run_vec_t;

    typedef struct {
        int addr;
        int data;
    } wr_vec_t;

    run_vec_t runs [2];
    wr_vec_t  wrv  [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  wr_hi, bad;
        bit  exp_wr;

        runs[0] = '{mode: 0, exp_cyc: 3072, exp_pass: 1, exp_err: 0, exp_ferr: 0};
        runs[1] = '{mode: 1, exp_cyc: 3072, exp_pass: 0, exp_err: 1, exp_ferr: 5};
        wrv[0]  = '{addr: 0,    data: 3};
        wrv[1]  = '{addr: 4,    data: 11};
        wrv[2]  = '{addr: 127,  data: 1};
        wrv[3]  = '{addr: 200,  data: 147};
        wrv[4]  = '{addr: 1023, data: 1};

        start_a = 0; start_b = 0; start_c = 0; mode = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_outs_a", {ram_addr_a, ram_din_a, ram_wr_a, ram_cs_a, busy_a, done_a,
                               pass_a, err_a, ferr_a}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("idle_busy_a", busy_a, 0);

        // healthy run, then stuck bit at addr 5
        for (int i = 0; i < 2; i++) begin
            mode = runs[i].mode;
            start_a = 1; tick(); start_a = 0;
            check("run_busy_rise", busy_a, 1);
            cyc = 0;
            while (!done_a && cyc < 4000) begin tick(); cyc++; end
            check("run_done_cyc", cyc, runs[i].exp_cyc);
            check("run_pass", pass_a, runs[i].exp_pass);
            check("run_err", err_a, runs[i].exp_err);
            check("run_ferr", ferr_a, runs[i].exp_ferr);
            check("run_busy_fall", busy_a, 0);
        end
        for (int i = 0; i < 5; i++)
            check($sformatf("wr_data_%0d", wrv[i].addr), wr_seen[wrv[i].addr], wrv[i].data);

        // restart from DONE clears the previous failing result on the accepting edge
        mode = 0;
        start_a = 1; tick(); start_a = 0;
        check("restart_done_clr", done_a, 0);
        check("restart_err_clr", err_a, 0);
        check("restart_ferr_clr", ferr_a, 0);
        check("restart_busy", busy_a, 1);
        // start held mid-write must not restart the sequence
        cyc = 0;
        repeat (100) begin tick(); cyc++; end
        start_a = 1;
        repeat (10) begin tick(); cyc++; end
        start_a = 0;
        while (!done_a && cyc < 4000) begin tick(); cyc++; end
        check("held_start_done_cyc", cyc, 3072);
        check("held_start_pass", pass_a, 1);
        start_a = 1; tick(); start_a = 0;
        check("restart_pass_clr", pass_a, 0);
        check("restart2_done_clr", done_a, 0);

        // asynchronous reset at cycle 500 of a run
        repeat (499) tick();
        check("pre_reset_busy", busy_a, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {ram_addr_a, ram_din_a, ram_wr_a, ram_cs_a, busy_a, done_a,
                                   pass_a, err_a, ferr_a}, 0);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_idle", {busy_a, done_a, ram_cs_a}, 0);
        start_a = 1; tick(); start_a = 0;
        cyc = 0;
        while (!done_a && cyc < 4000) begin tick(); cyc++; end
        check("post_reset_done_cyc", cyc, 3072);
        check("post_reset_pass", pass_a, 1);

        // write-ignoring ram: 32 mismatches saturate a 4-bit counter
        start_b = 1; tick(); start_b = 0;
        cyc = 0;
        while (!done_b && cyc < 200) begin tick(); cyc++; end
        check("sat_done_cyc", cyc, 96);
        check("sat_err", err_b, 15);
        check("sat_ferr", ferr_b, 0);
        check("sat_pass", pass_b, 0);

        // small config: wr pulse shape and timing
        start_c = 1; tick(); start_c = 0;
        cyc = 0; wr_hi = 0; bad = 0;
        if (ram_wr_c !== 1'b1) bad++;
        wr_hi += int'(ram_wr_c);
        while (!done_c && cyc < 200) begin
            tick(); cyc++;
            exp_wr = (cyc < 32) && (cyc % 2 == 0);
            if (ram_wr_c !== exp_wr) bad++;
            wr_hi += int'(ram_wr_c);
        end
        check("small_done_cyc", cyc, 48);
        check("small_wr_pulses", wr_hi, 16);
        check("small_wr_shape_bad", bad, 0);
        check("small_pass", pass_c, 1);
        check("small_err", err_c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
